aq_mp_clk_ratio_ctrl: RTL and testbench
=======================================

// Module: aq_mp_clk_ratio_ctrl
// PURPOSE
//  Programmable clock-enable scheduler for the MP clock top. It replaces the fixed
//  divide-by-2 peripheral enable with a runtime-selectable divide-by-(R+1) enable.
//  Ratio changes use a req/ack handshake. A change is applied only when the bus is idle
//  and on a period boundary, so that no shortened or merged enable period is produced.
//  Output clk_en_f drives the CE of the peripheral (APB) clock buffer.
// PARAMETERS
//  RATIO_W    4    width of the ratio field; divide factor = ratio+1 (1..16)
//  DEF_RATIO  1    ratio loaded at reset (divide-by-2)
//  TMO_W      8    width of the bus-idle wait counter
//  IDLE_TMO   255  cycles to wait for bus_idle before forcing the switch
// PORTS
//  forever_cpuclk    in   1        free-running core clock
//  clkgen_rst_b      in   1        async active-low reset
//  pad_yy_scan_mode  in   1        scan mode; forces clk_en high
//  ratio_req         in   1        ratio change request; held until ratio_ack
//  ratio_val         in   RATIO_W  requested ratio; stable while ratio_req is high
//  bus_idle          in   1        peripheral bus has no transfer in flight
//  ratio_ack         out  1        1-cycle pulse: request completed
//  ratio_tmo         out  1        1-cycle pulse together with ratio_ack when the switch was forced
//  ratio_cur         out  RATIO_W  ratio currently in effect
//  busy              out  1        FSM not in RUN
//  clk_en_f          out  1        registered enable pulse, 1 cycle every ratio_cur+1 cycles
//  clk_en            out  1        pad_yy_scan_mode ? 1'b1 : clk_en_f
// BEHAVIOUR
//  Reset: clocked on forever_cpuclk; clkgen_rst_b is asynchronous, active-low.
//   Reset values: cnt=0, ratio_cur=DEF_RATIO, clk_en_f=0, ratio_ack=0, ratio_tmo=0,
//   state=RUN, busy=0.
//  Counter: cnt increments each cycle and wraps to 0 when cnt==ratio_cur.
//   clk_en_f <= (cnt==ratio_cur).
//   ratio 0 -> clk_en_f high continuously, starting from the 1st edge after reset release.
//   First pulse is high after rising edge number ratio_cur+1 following reset release.
//  FSM states: RUN, WAIT_IDLE, WAIT_BND.
//   RUN: when ratio_req=1 and ratio_ack=0:
//    - if ratio_val==ratio_cur: ratio_ack<=1, stay in RUN, counter phase untouched.
//    - else: pend<=ratio_val, tmo_cnt<=0, go to WAIT_IDLE.
//   WAIT_IDLE:
//    - bus_idle=1 -> go to WAIT_BND.
//    - else tmo_cnt++. When tmo_cnt==IDLE_TMO: set the tmo flag and go to WAIT_BND.
//   WAIT_BND: in the cycle where cnt==ratio_cur (a pulse is being generated):
//    - ratio_cur<=pend, cnt<=0, ratio_ack<=1, ratio_tmo<=tmo flag, clear flag, go to RUN.
//    - bus_idle is not rechecked in WAIT_BND.
//  The period after a switch is exactly pend+1 cycles. No glitch or short period is allowed.
//  ratio_ack and ratio_tmo last one cycle.
//   A request held high in the ack cycle is ignored; the requester drops req after ack.
//  ratio_req dropping before ack is a protocol violation; the FSM completes regardless.
//  Scan mode only affects clk_en. The counter and FSM keep running.
//  Reset mid-operation: pending request discarded, no ack, ratio_cur=DEF_RATIO.
//  busy = (state != RUN).
// TESTING
//  1 Reset release with DEF_RATIO=1 -> clk_en_f = 0,1,0,1... First high after edge 2.
//    ratio_cur=1.
//  2 bus_idle=1, request ratio 3 -> ack within 2+2 cycles.
//    Then clk_en_f high every 4 cycles. The first new period is exactly 4 cycles.
//  3 bus_idle=0 for 10 cycles, then 1 -> busy high throughout, no switch while idle is low.
//    Ack follows the next boundary; ratio_tmo=0.
//  4 IDLE_TMO=16 with bus_idle stuck at 0 -> switch after 16 cycles plus boundary.
//    ratio_ack and ratio_tmo pulse together.
//  5 Request ratio_val equal to ratio_cur -> ack the next cycle.
//    Pulse phase unchanged; busy stays 0.
//  6 Scan mode=1 -> clk_en constant 1.
//    Reset asserted in WAIT_BND -> no ack; ratio_cur=1 and cnt=0 after release.

Source files
------------

// File: rtl/aq_mp_clk_ratio_ctrl.sv
// -----------------------------------------------------------------------------
// aq_mp_clk_ratio_ctrl
//
// Programmable clock-enable scheduler for the MP clock top. Produces a one-cycle
// enable pulse every (ratio_cur+1) cycles of forever_cpuclk for the CE input of
// the peripheral (APB) clock buffer. The ratio can be changed at run time with a
// req/ack handshake. A new ratio only takes effect once the peripheral bus is
// idle, or once the idle wait has timed out. It is also applied only on a period
// boundary, so no shortened or merged enable period is ever produced.
//
// Ports
//   forever_cpuclk    in   free-running core clock
//   clkgen_rst_b      in   asynchronous active-low reset
//   pad_yy_scan_mode  in   scan mode; forces clk_en high
//   ratio_req         in   ratio change request, held until ratio_ack
//   ratio_val         in   requested ratio (divide factor = ratio_val+1)
//   bus_idle          in   peripheral bus has no transfer in flight
//   ratio_ack         out  one-cycle pulse: request completed
//   ratio_tmo         out  one-cycle pulse with ratio_ack when the switch was forced
//   ratio_cur         out  ratio currently in effect
//   busy              out  a change is in progress
//   clk_en_f          out  registered enable pulse, 1 cycle every ratio_cur+1 cycles
//   clk_en            out  clk_en_f, forced high in scan mode
// -----------------------------------------------------------------------------
module aq_mp_clk_ratio_ctrl #(
    parameter int RATIO_W   = 4,
    parameter int DEF_RATIO = 1,
    parameter int TMO_W     = 8,
    parameter int IDLE_TMO  = 255
) (
    input  logic               forever_cpuclk,
    input  logic               clkgen_rst_b,
    input  logic               pad_yy_scan_mode,
    input  logic               ratio_req,
    input  logic [RATIO_W-1:0] ratio_val,
    input  logic               bus_idle,
    output logic               ratio_ack,
    output logic               ratio_tmo,
    output logic [RATIO_W-1:0] ratio_cur,
    output logic               busy,
    output logic               clk_en_f,
    output logic               clk_en
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_IDLE = 2'd1,
        WAIT_BND  = 2'd2
    } state_t;

    localparam logic [RATIO_W-1:0] DEF_RATIO_C = RATIO_W'(DEF_RATIO);
    localparam logic [RATIO_W-1:0] CNT_ONE_C   = RATIO_W'(1);
    localparam logic [TMO_W-1:0]   IDLE_TMO_C  = TMO_W'(IDLE_TMO);
    localparam logic [TMO_W-1:0]   TMO_ONE_C   = TMO_W'(1);

    state_t             state_r;
    logic [RATIO_W-1:0] cnt_r;
    logic [RATIO_W-1:0] pend_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic               tmo_flag_r;
    logic               bnd_s;

    // The last cycle of the current period; the pulse for it is being registered now.
    assign bnd_s = (cnt_r == ratio_cur);

    // Scan mode bypass of the registered enable.
    assign clk_en = pad_yy_scan_mode | clk_en_f;

    // Period counter and registered enable pulse. A ratio switch always lands on
    // bnd_s, so the wrap to zero here also restarts the new period cleanly.
    always_ff @(posedge forever_cpuclk or negedge clkgen_rst_b) begin
        if (!clkgen_rst_b) begin
            cnt_r    <= {RATIO_W{1'b0}};
            clk_en_f <= 1'b0;
        end else begin
            clk_en_f <= bnd_s;
            if (bnd_s) begin
                cnt_r <= {RATIO_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_ONE_C;
            end
        end
    end

    // Ratio change FSM with registered handshake outputs.
    always_ff @(posedge forever_cpuclk or negedge clkgen_rst_b) begin
        if (!clkgen_rst_b) begin
            state_r    <= RUN;
            ratio_cur  <= DEF_RATIO_C;
            pend_r     <= DEF_RATIO_C;
            tmo_cnt_r  <= {TMO_W{1'b0}};
            tmo_flag_r <= 1'b0;
            ratio_ack  <= 1'b0;
            ratio_tmo  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ratio_ack <= 1'b0;
            ratio_tmo <= 1'b0;
            case (state_r)
                RUN: begin
                    // A request still high during its own ack cycle is not a new one.
                    if (ratio_req && !ratio_ack) begin
                        if (ratio_val == ratio_cur) begin
                            ratio_ack <= 1'b1;
                        end else begin
                            pend_r     <= ratio_val;
                            tmo_cnt_r  <= {TMO_W{1'b0}};
                            tmo_flag_r <= 1'b0;
                            state_r    <= WAIT_IDLE;
                            busy       <= 1'b1;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                WAIT_IDLE: begin
                    if (bus_idle) begin
                        state_r <= WAIT_BND;
                    end else if (tmo_cnt_r == IDLE_TMO_C) begin
                        tmo_flag_r <= 1'b1;
                        state_r    <= WAIT_BND;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_ONE_C;
                    end
                end
                WAIT_BND: begin
                    // Bus idleness is deliberately not re-evaluated here.
                    if (bnd_s) begin
                        ratio_cur  <= pend_r;
                        ratio_ack  <= 1'b1;
                        ratio_tmo  <= tmo_flag_r;
                        tmo_flag_r <= 1'b0;
                        state_r    <= RUN;
                        busy       <= 1'b0;
                    end else begin
                        state_r <= WAIT_BND;
                    end
                end
                default: begin
                    state_r <= RUN;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aq_mp_clk_ratio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aq_mp_clk_ratio_ctrl
//
// Randomised bench with a behavioural reference model. The model tracks
// the phase within the enable period and any outstanding ratio request. Each
// completed request pushes its expected ack (ratio, forced flag) onto a
// scoreboard queue. A monitor pops one entry per observed ratio_ack and compares
// it, and also compares the per-cycle outputs against the model.
// -----------------------------------------------------------------------------
module tb_aq_mp_clk_ratio_ctrl;

    localparam int RW  = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          scan = 1'b0;
    logic          req = 1'b0;
    logic [RW-1:0] val = 4'd0;
    logic          idle = 1'b1;
    logic          ratio_ack, ratio_tmo, busy, clk_en_f, clk_en;
    logic [RW-1:0] ratio_cur;

    aq_mp_clk_ratio_ctrl #(
        .RATIO_W(RW), .DEF_RATIO(1), .TMO_W(8), .IDLE_TMO(TMO)
    ) dut (
        .forever_cpuclk  (clk),
        .clkgen_rst_b    (rst_b),
        .pad_yy_scan_mode(scan),
        .ratio_req       (req),
        .ratio_val       (val),
        .bus_idle        (idle),
        .ratio_ack       (ratio_ack),
        .ratio_tmo       (ratio_tmo),
        .ratio_cur       (ratio_cur),
        .busy            (busy),
        .clk_en_f        (clk_en_f),
        .clk_en          (clk_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int tmo;
        int ratio;
    } exp_t;
    exp_t sb[$];

    int m_ratio, m_phase, m_en, m_ack;
    int m_pend, m_target, m_idle_ok, m_wait, m_forced;
    int m_pulse, m_prev_ack;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_ratio = 1; m_phase = 0; m_en = 0; m_ack = 0;
            m_pend = 0; m_target = 0; m_idle_ok = 0; m_wait = 0; m_forced = 0;
            sb.delete();
        end else begin
            m_pulse    = (m_phase == m_ratio) ? 1 : 0;
            m_prev_ack = m_ack;
            m_ack      = 0;
            if (m_pend != 0) begin
                if (m_idle_ok == 0) begin
                    if (idle) m_idle_ok = 1;
                    else if (m_wait == TMO) begin m_forced = 1; m_idle_ok = 1; end
                    else m_wait++;
                end else if (m_pulse != 0) begin
                    m_ratio = m_target;
                    m_ack   = 1;
                    m_pend  = 0;
                    sb.push_back('{m_forced, m_target});
                end
            end else if (req && m_prev_ack == 0) begin
                if (int'(val) == m_ratio) begin
                    m_ack = 1;
                    sb.push_back('{0, m_ratio});
                end else begin
                    m_pend = 1; m_target = int'(val);
                    m_idle_ok = 0; m_wait = 0; m_forced = 0;
                end
            end
            m_phase = (m_pulse != 0) ? 0 : m_phase + 1;
            m_en    = m_pulse;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    exp_t e;
    always @(posedge clk) begin
        #2;
        chk("clk_en_f", int'(clk_en_f), m_en);
        chk("clk_en", int'(clk_en), scan ? 1 : m_en);
        chk("ratio_cur", int'(ratio_cur), m_ratio);
        chk("busy", int'(busy), m_pend);
        if (ratio_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("ack_tmo", int'(ratio_tmo), e.tmo);
                chk("ack_ratio", int'(ratio_cur), e.ratio);
            end
        end else begin
            chk("tmo_without_ack", int'(ratio_tmo), 0);
        end
        chk("missed_ack", sb.size(), 0);
    end

    // ---------------- stimulus ----------------
    // mode 0: idle high, 1: idle low 10 cycles then high, 2: idle stuck low, 3: random
    task automatic do_req(input int v, input int mode);
        int n;
        @(negedge clk);
        req = 1'b1;
        val = RW'(v);
        idle = (mode == 0) ? 1'b1 : (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        n = 0;
        forever begin
            @(posedge clk);
            #2;
            if (ratio_ack) break;
            n++;
            if (n > 300) begin
                chk("ack_timeout", 0, 1);
                break;
            end
            @(negedge clk);
            case (mode)
                0:       idle = 1'b1;
                1:       idle = (n >= 10) ? 1'b1 : 1'b0;
                2:       idle = 1'b0;
                default: idle = 1'($urandom_range(0, 1));
            endcase
        end
        @(negedge clk);
        req  = 1'b0;
        idle = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // reset release, default ratio 1
        idle_cycles(3);
        rst_b = 1'b1;
        idle_cycles(8);
        chk("ratio_after_reset", int'(ratio_cur), 1);

        do_req(3, 0);          // idle bus
        idle_cycles(12);
        do_req(5, 1);          // idle low for 10 cycles first
        idle_cycles(10);
        do_req(2, 2);          // idle stuck low, forced switch
        idle_cycles(6);
        do_req(2, 0);          // same ratio, immediate ack
        idle_cycles(6);
        do_req(0, 0);          // continuous enable
        idle_cycles(5);

        scan = 1'b1;           // scan bypass
        idle_cycles(10);
        do_req(7, 0);
        idle_cycles(10);
        scan = 1'b0;

        for (int i = 0; i < 20; i++) begin
            do_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            idle_cycles(int'($urandom_range(0, 5)));
        end

        // reset asserted while waiting for the period boundary
        do_req(15, 0);
        @(negedge clk);
        req = 1'b1;
        val = 4'd4;
        idle_cycles(4);
        chk("busy_before_reset", int'(busy), 1);
        #2 rst_b = 1'b0;
        req = 1'b0;
        idle_cycles(3);
        rst_b = 1'b1;
        @(posedge clk);
        #2;
        chk("ratio_after_midrst", int'(ratio_cur), 1);
        idle_cycles(10);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
